// File: rtl/decoder_pipe_pkg.sv
// Shared constants and helpers for the pipelined multi-port register-file write decoder.
package decoder_pipe_pkg;

  localparam int MAX_PORTS  = 4;
  localparam int MAX_STAGES = 2;

  // Selects which pipeline point feeds the conflict counter.
  typedef enum logic [1:0] {
    STG_IN   = 2'd0,
    STG_DEC  = 2'd1,
    STG_PIPE = 2'd2
  } stage_sel_e;

  function automatic int code_w(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/decoder_pipe_if.sv
// Request/response bundle between a decoder_pipe and its driver.
interface decoder_pipe_if #(
  parameter int WIDTH = 4,
  parameter int PORTS = 2,
  parameter int CNT_W = 8
);
  localparam int CW = decoder_pipe_pkg::code_w(WIDTH);

  logic                     clken;
  logic [PORTS*WIDTH-1:0]   addr;
  logic [PORTS-1:0]         en;
  logic [PORTS*CW-1:0]      code;
  logic [CW-1:0]            code_any;
  logic                     valid;
  logic                     conflict;
  logic [CNT_W-1:0]         conflict_cnt;

  modport master (
    output clken, addr, en,
    input  code, code_any, valid, conflict, conflict_cnt
  );

  modport slave (
    input  clken, addr, en,
    output code, code_any, valid, conflict, conflict_cnt
  );

endinterface

// File: rtl/decoder_pipe_onehot.sv
// Single-channel WIDTH-to-2**WIDTH one-hot decoder with enable; purely combinational.
module decoder_onehot
  import decoder_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]          addr,
  input  logic                      en,
  output logic [code_w(WIDTH)-1:0]  code
);
  localparam int CW = code_w(WIDTH);

  assign code = en ? (CW'(1) << addr) : '0;

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined multi-port address decoder with fixed lowest-index priority and a saturating conflict counter.
// Optional build macro DECODER_PIPE_ZERO_MASK_EN suppresses decoding of address 0.
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int PORTS  = 2,
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_pipe_if.slave  bus
);
  localparam int CW = code_w(WIDTH);
  localparam stage_sel_e CNT_TAP = (STAGES == MAX_STAGES) ? STG_PIPE : STG_DEC;

  logic [PORTS-1:0][WIDTH-1:0] addr_v;
  logic [PORTS-1:0]            en_eff;
  logic [PORTS-1:0][CW-1:0]    raw;
  logic [PORTS-1:0][CW-1:0]    code_s1;
  logic [CW-1:0]               any_s1;
  logic                        valid_s1;
  logic                        conflict_s1;

  assign addr_v = bus.addr;

  for (genvar p = 0; p < PORTS; p++) begin : g_lane
`ifdef DECODER_PIPE_ZERO_MASK_EN
    // $zero is never a write target, so such a channel is treated as idle.
    assign en_eff[p] = bus.en[p] & (addr_v[p] != '0);
`else
    assign en_eff[p] = bus.en[p];
`endif
    decoder_onehot #(.WIDTH(WIDTH)) u_dec (
      .addr (addr_v[p]),
      .en   (en_eff[p]),
      .code (raw[p])
    );
  end

  always_comb begin
    logic [CW-1:0] claimed;
    claimed = '0;
    for (int p = 0; p < PORTS; p++) begin
      code_s1[p] = raw[p] & ~claimed;
      claimed    = claimed | raw[p];
    end
    any_s1 = claimed;
  end

  always_comb begin
    conflict_s1 = 1'b0;
    for (int i = 0; i < PORTS; i++)
      for (int j = i + 1; j < PORTS; j++)
        if (en_eff[i] && en_eff[j] && (addr_v[i] == addr_v[j]))
          conflict_s1 = 1'b1;
  end

  assign valid_s1 = |en_eff;

  logic [PORTS-1:0][CW-1:0] code_q [1:STAGES];
  logic [CW-1:0]            any_q  [1:STAGES];
  logic [STAGES:1]          vld_pipe;
  logic [STAGES:1]          conf_pipe;
  logic [CNT_W-1:0]         cnt_q;
  logic                     conf_load;

  // The counter watches whatever is about to land in the output stage.
  if (CNT_TAP == STG_DEC) begin : g_tap_s1
    assign conf_load = conflict_s1;
  end else begin : g_tap_pipe
    assign conf_load = conf_pipe[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= STAGES; s++) begin
        code_q[s] <= '0;
        any_q[s]  <= '0;
      end
      vld_pipe  <= '0;
      conf_pipe <= '0;
      cnt_q     <= '0;
    end else if (bus.clken) begin
      code_q[1]    <= code_s1;
      any_q[1]     <= any_s1;
      vld_pipe[1]  <= valid_s1;
      conf_pipe[1] <= conflict_s1;
      for (int s = 2; s <= STAGES; s++) begin
        code_q[s]    <= code_q[s-1];
        any_q[s]     <= any_q[s-1];
        vld_pipe[s]  <= vld_pipe[s-1];
        conf_pipe[s] <= conf_pipe[s-1];
      end
      if (conf_load && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.code         = code_q[STAGES];
  assign bus.code_any     = any_q[STAGES];
  assign bus.valid        = vld_pipe[STAGES];
  assign bus.conflict     = conf_pipe[STAGES];
  assign bus.conflict_cnt = cnt_q;

  logic [CW-1:0] seen, overlap;
  always_comb begin
    seen    = '0;
    overlap = '0;
    for (int p = 0; p < PORTS; p++) begin
      overlap = overlap | (seen & code_q[STAGES][p]);
      seen    = seen | code_q[STAGES][p];
    end
  end

  a_code_exclusive: assert property (@(posedge clk) disable iff (!rst_n) overlap == '0);
  a_any_bounded:    assert property (@(posedge clk) disable iff (!rst_n)
                                     $countones(bus.code_any) <= PORTS);
`ifdef DECODER_PIPE_ZERO_MASK_EN
  a_zero_masked:    assert property (@(posedge clk) disable iff (!rst_n) !bus.code_any[0]);
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized scoreboard bench for decoder_pipe against a behavioural priority-decode model.
module tb_decoder_pipe;
  localparam int WIDTH  = 4;
  localparam int PORTS  = 2;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;
  localparam int CW     = 1 << WIDTH;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decoder_pipe_if #(.WIDTH(WIDTH), .PORTS(PORTS), .CNT_W(CNT_W)) bus ();

  decoder_pipe #(.WIDTH(WIDTH), .PORTS(PORTS), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PORTS*CW-1:0] code;
    logic [CW-1:0]       any;
    logic                valid;
    logic                conflict;
  } res_t;

  typedef struct {
    res_t r;
    int   cnt;
  } snap_t;

  res_t  pipe[$];
  snap_t exp_q[$];
  int    model_cnt;
  int    checks = 0;
  int    failures = 0;
  bit    drive_done = 0;

  function automatic res_t zero_res();
    res_t z;
    z.code = '0; z.any = '0; z.valid = 1'b0; z.conflict = 1'b0;
    return z;
  endfunction

  // Channels claim addresses in index order; a second claim of the same address is a conflict.
  function automatic res_t model(input logic [PORTS*WIDTH-1:0] a, input logic [PORTS-1:0] e);
    res_t r;
    int   hits [CW];
    int   ad;
    r = zero_res();
    for (int i = 0; i < CW; i++) hits[i] = 0;
    for (int p = 0; p < PORTS; p++) begin
      if (e[p]) begin
        ad = int'(a[p*WIDTH +: WIDTH]);
`ifdef DECODER_PIPE_ZERO_MASK_EN
        if (ad == 0) continue;
`endif
        r.valid = 1'b1;
        if (hits[ad] == 0) r.code[p*CW + ad] = 1'b1;
        hits[ad]++;
        r.any[ad] = 1'b1;
      end
    end
    for (int i = 0; i < CW; i++) if (hits[i] > 1) r.conflict = 1'b1;
    return r;
  endfunction

  task automatic step(input logic r, input logic ck,
                      input logic [PORTS*WIDTH-1:0] a, input logic [PORTS-1:0] e);
    res_t  tmp;
    snap_t s;
    @(negedge clk);
    rst_n     = r;
    bus.clken = ck;
    bus.addr  = a;
    bus.en    = e;
    if (!r) begin
      pipe.delete();
      for (int i = 0; i < STAGES; i++) pipe.push_back(zero_res());
      model_cnt = 0;
    end else if (ck) begin
      pipe.push_front(model(a, e));
      tmp = pipe.pop_back();
      if (pipe[STAGES-1].conflict && model_cnt < CMAX) model_cnt++;
    end
    s.r   = pipe[STAGES-1];
    s.cnt = model_cnt;
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("code",         64'(bus.code),         64'(s.r.code));
        chk("code_any",     64'(bus.code_any),     64'(s.r.any));
        chk("valid",        64'(bus.valid),        64'(s.r.valid));
        chk("conflict",     64'(bus.conflict),     64'(s.r.conflict));
        chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(s.cnt));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [PORTS*WIDTH-1:0] pack2(input int a1, input int a0);
    return {WIDTH'(a1), WIDTH'(a0)};
  endfunction

  initial begin : driver
    logic [WIDTH-1:0] a0, a1;
    rst_n = 1'b0; bus.clken = 1'b1; bus.addr = '0; bus.en = '0;
    model_cnt = 0;
    for (int i = 0; i < STAGES; i++) pipe.push_back(zero_res());

    // reset with requests present
    repeat (2) step(1'b0, 1'b1, pack2(5, 5), 2'b11);
    // single channel decode, then drain
    step(1'b1, 1'b1, pack2(0, 3), 2'b01);
    repeat (3) step(1'b1, 1'b1, '0, 2'b00);
    // sustained conflict drives the counter into saturation
    repeat (262) step(1'b1, 1'b1, pack2(7, 7), 2'b11);
    repeat (3) step(1'b1, 1'b1, '0, 2'b00);
    // stall: inputs during clken=0 must be ignored
    step(1'b1, 1'b1, pack2(0, 9), 2'b01);
    repeat (3) step(1'b1, 1'b0, pack2(4, 4), 2'b11);
    repeat (2) step(1'b1, 1'b1, '0, 2'b00);
    // top address and address zero
    step(1'b1, 1'b1, pack2(15, 0), 2'b10);
    step(1'b1, 1'b1, pack2(0, 0), 2'b01);
    step(1'b1, 1'b1, pack2(0, 0), 2'b11);
    repeat (3) step(1'b1, 1'b1, '0, 2'b00);
    // reset lands while a conflict is still inside the pipe
    step(1'b1, 1'b1, pack2(7, 7), 2'b11);
    step(1'b0, 1'b1, pack2(7, 7), 2'b11);
    repeat (3) step(1'b1, 1'b1, '0, 2'b00);

    for (int i = 0; i < 1500; i++) begin
      a0 = WIDTH'($urandom);
      a1 = ($urandom_range(0, 9) < 3) ? a0 : WIDTH'($urandom);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
           {a1, a0}, PORTS'($urandom));
    end
    drive_done = 1;
  end

  initial begin : finisher
    wait (drive_done);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
